axi_mm_slave_mem: RTL and testbench

//  Synthesizable AXI4 memory-mapped slave memory serving DMA MM2S reads and S2MM writes.

---
 rtl/axi_mm_slave_mem.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_mm_slave_mem.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm_slave_mem.sv
// AXI4 memory-mapped slave memory with independent read and write burst engines.
// Supports INCR/FIXED bursts, byte strobes, programmable read latency and SLVERR.
module axi_mm_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RD_LATENCY = 2
) (
  input  logic                    axi_aclk,
  input  logic                    axi_reset,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready
);

  localparam int          STRB_W     = DATA_WIDTH / 8;
  localparam int          BYTE_SHIFT = $clog2(STRB_W);
  localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES  = 64'(DEPTH) * 64'(STRB_W);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [63:0] off;
    off = 64'(a) - 64'(BASE_ADDR);
    return (64'(a) >= 64'(BASE_ADDR)) && (off < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [63:0] off;
    off = 64'(a) - 64'(BASE_ADDR);
    return IDX_W'(off >> BYTE_SHIFT);
  endfunction

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size > 3'(BYTE_SHIFT));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (ADDR_WIDTH'(1) << size);
  endfunction

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [3:0]            r_wait;

  logic [ADDR_WIDTH-1:0] rd_ld_addr;
  logic [2:0]            rd_ld_size;
  logic [1:0]            rd_ld_burst;
  logic                  rd_ld_err;
  logic [DATA_WIDTH-1:0] rd_ld_data;

  // Address of the beat about to be presented: the AR request itself, the
  // latched start address, or the successor of the beat being accepted.
  always_comb begin
    rd_ld_addr  = r_addr;
    rd_ld_size  = r_size;
    rd_ld_burst = r_burst;
    case (r_state)
      R_IDLE: begin
        rd_ld_addr  = s_araddr;
        rd_ld_size  = s_arsize;
        rd_ld_burst = s_arburst;
      end
      R_BURST: rd_ld_addr = next_addr(r_addr, r_size, r_burst);
      default: ;
    endcase
    rd_ld_err  = burst_bad(rd_ld_burst, rd_ld_size) || !addr_ok(rd_ld_addr);
    rd_ld_data = rd_ld_err ? '0 : mem[word_idx(rd_ld_addr)];
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= 2'b00;
      s_rlast   <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_wait    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_arready <= 1'b1;
          if (s_arvalid && s_arready) begin
            s_arready <= 1'b0;
            r_addr    <= s_araddr;
            r_len     <= s_arlen;
            r_size    <= s_arsize;
            r_burst   <= s_arburst;
            r_beat    <= '0;
            if (RD_LATENCY == 0) begin
              r_state  <= R_BURST;
              s_rvalid <= 1'b1;
              s_rlast  <= (s_arlen == 8'd0);
              s_rdata  <= rd_ld_data;
              s_rresp  <= rd_ld_err ? 2'b10 : 2'b00;
            end else begin
              r_state <= R_WAIT;
              r_wait  <= 4'(RD_LATENCY - 1);
            end
          end
        end
        R_WAIT: begin
          if (r_wait == 4'd0) begin
            r_state  <= R_BURST;
            s_rvalid <= 1'b1;
            s_rlast  <= (r_len == 8'd0);
            s_rdata  <= rd_ld_data;
            s_rresp  <= rd_ld_err ? 2'b10 : 2'b00;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        R_BURST: begin
          if (s_rready) begin
            if (r_beat == r_len) begin
              r_state   <= R_IDLE;
              s_rvalid  <= 1'b0;
              s_rlast   <= 1'b0;
              s_arready <= 1'b1;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_addr  <= rd_ld_addr;
              s_rlast <= (r_beat + 8'd1 == r_len);
              s_rdata <= rd_ld_data;
              s_rresp <= rd_ld_err ? 2'b10 : 2'b00;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_beat;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  w_beat_err;
  logic                  w_last_beat;
  logic                  w_now_err;
  logic                  mem_we;

  always_comb begin
    w_beat_err  = burst_bad(w_burst, w_size) || !addr_ok(w_addr);
    w_last_beat = (w_beat == w_len);
    w_now_err   = w_beat_err || (s_wlast != w_last_beat);
    mem_we      = s_wready && s_wvalid && !axi_reset && !w_beat_err;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= 2'b00;
      w_addr    <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_awready <= 1'b1;
          if (s_awvalid && s_awready) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b1;
            w_state   <= W_DATA;
            w_addr    <= s_awaddr;
            w_len     <= s_awlen;
            w_size    <= s_awsize;
            w_burst   <= s_awburst;
            w_beat    <= '0;
            w_err     <= 1'b0;
          end
        end
        W_DATA: begin
          // The burst length comes from AW; wlast only contributes to the error flag.
          if (s_wvalid) begin
            if (w_last_beat) begin
              w_state  <= W_RESP;
              s_wready <= 1'b0;
              s_bvalid <= 1'b1;
              s_bresp  <= (w_err || w_now_err) ? 2'b10 : 2'b00;
            end else begin
              w_err  <= w_err || w_now_err;
              w_beat <= w_beat + 8'd1;
              w_addr <= next_addr(w_addr, w_size, w_burst);
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            w_state   <= W_IDLE;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
            s_awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mm_slave_mem.sv
// Directed self-checking bench for axi_mm_slave_mem (32-bit data, 1024 words, read latency 2).
module tb_axi_mm_slave_mem;

  logic        axi_aclk = 1'b0;
  logic        axi_reset = 1'b1;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = '0;
  logic [1:0]  s_arburst = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [31:0] s_awaddr = '0;
  logic [7:0]  s_awlen = '0;
  logic [2:0]  s_awsize = '0;
  logic [1:0]  s_awburst = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wlast = 1'b0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] wbeat_data [16];
  logic [3:0]  wbeat_strb [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_latency;
  logic [1:0]  wr_resp;

  axi_mm_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h0), .RD_LATENCY(2)
  ) dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    axi_reset = 1'b1;
    s_arvalid = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_rready  = 1'b0;
    s_bready  = 1'b0;
    repeat (cycles) @(negedge axi_aclk);
  endtask

  // Handshakes are sampled and driven on the falling edge so each ready seen
  // there is the value the DUT presents at the next rising edge.
  task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int wrong_last_beat);
    int n;
    s_awaddr = addr; s_awlen = len; s_awsize = 3'd2; s_awburst = burst; s_awvalid = 1'b1;
    n = 0;
    while (!s_awready && n < 20) begin @(negedge axi_aclk); n++; end
    checkOutput("aw_handshake", 32'(n < 20), 32'd1);
    @(negedge axi_aclk);
    s_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_wdata = wbeat_data[b]; s_wstrb = wbeat_strb[b];
      s_wlast = (b == int'(len)) ^ (b == wrong_last_beat);
      s_wvalid = 1'b1;
      n = 0;
      while (!s_wready && n < 20) begin @(negedge axi_aclk); n++; end
      checkOutput("w_handshake", 32'(n < 20), 32'd1);
      @(negedge axi_aclk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
    n = 0;
    while (!s_bvalid && n < 20) begin @(negedge axi_aclk); n++; end
    checkOutput("b_handshake", 32'(n < 20), 32'd1);
    wr_resp = s_bresp;
    @(negedge axi_aclk);
    s_bready = 1'b0;
  endtask

  task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int stall_beat, input int stall_cycles);
    int n;
    s_araddr = addr; s_arlen = len; s_arsize = 3'd2; s_arburst = burst;
    s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge axi_aclk); n++; end
    checkOutput("ar_handshake", 32'(n < 20), 32'd1);
    @(negedge axi_aclk);
    s_arvalid = 1'b0;
    n = 1;
    while (!s_rvalid && n < 40) begin @(negedge axi_aclk); n++; end
    rd_latency = n;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!s_rvalid && n < 20) begin @(negedge axi_aclk); n++; end
      checkOutput("r_beat_valid", 32'(n < 20), 32'd1);
      if (b == stall_beat) begin
        s_rready = 1'b0;
        repeat (stall_cycles) @(negedge axi_aclk);
        checkOutput("r_stall_valid", 32'(s_rvalid), 32'd1);
        s_rready = 1'b1;
      end
      rd_data[b] = s_rdata; rd_resp[b] = s_rresp; rd_last[b] = s_rlast;
      @(negedge axi_aclk);
    end
    checkOutput("r_done_valid", 32'(s_rvalid), 32'd0);
  endtask

  initial begin
    int n;

    applyStimulus(3);
    checkOutput("rst_arready", 32'(s_arready), 32'd0);
    checkOutput("rst_awready", 32'(s_awready), 32'd0);
    checkOutput("rst_rvalid", 32'(s_rvalid), 32'd0);
    checkOutput("rst_wready", 32'(s_wready), 32'd0);
    checkOutput("rst_bvalid", 32'(s_bvalid), 32'd0);
    checkOutput("rst_rdata", s_rdata, 32'h0);
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    checkOutput("post_rst_arready", 32'(s_arready), 32'd1);
    checkOutput("post_rst_awready", 32'(s_awready), 32'd1);

    // INCR write then read-back with latency and rlast checks
    for (int i = 0; i < 4; i++) begin wbeat_data[i] = 32'hA0 + 32'(i); wbeat_strb[i] = 4'hF; end
    writeBurst(32'h10, 8'd3, 2'b01, -1);
    checkOutput("incr_bresp", 32'(wr_resp), 32'd0);
    readBurst(32'h10, 8'd3, 2'b01, -1, 0);
    checkOutput("incr_latency", 32'(rd_latency), 32'd3);
    checkOutput("incr_d0", rd_data[0], 32'hA0);
    checkOutput("incr_d1", rd_data[1], 32'hA1);
    checkOutput("incr_d2", rd_data[2], 32'hA2);
    checkOutput("incr_d3", rd_data[3], 32'hA3);
    checkOutput("incr_last0", 32'(rd_last[0]), 32'd0);
    checkOutput("incr_last2", 32'(rd_last[2]), 32'd0);
    checkOutput("incr_last3", 32'(rd_last[3]), 32'd1);
    checkOutput("incr_resp1", 32'(rd_resp[1]), 32'd0);

    // Byte strobes merge into the existing word
    wbeat_data[0] = 32'h11223344; wbeat_strb[0] = 4'hF;
    writeBurst(32'h0, 8'd0, 2'b01, -1);
    wbeat_data[0] = 32'hAABBCCDD; wbeat_strb[0] = 4'b0101;
    writeBurst(32'h0, 8'd0, 2'b01, -1);
    readBurst(32'h0, 8'd0, 2'b01, -1, 0);
    checkOutput("strb_merge", rd_data[0], 32'h11BB33DD);
    checkOutput("strb_last", 32'(rd_last[0]), 32'd1);

    // FIXED write keeps hitting one word; its neighbour stays intact
    wbeat_data[0] = 32'h5555AAAA; wbeat_strb[0] = 4'hF;
    writeBurst(32'h24, 8'd0, 2'b01, -1);
    for (int i = 0; i < 3; i++) begin wbeat_data[i] = 32'(i + 1); wbeat_strb[i] = 4'hF; end
    writeBurst(32'h20, 8'd2, 2'b00, -1);
    checkOutput("fixed_bresp", 32'(wr_resp), 32'd0);
    readBurst(32'h20, 8'd1, 2'b01, -1, 0);
    checkOutput("fixed_word", rd_data[0], 32'h3);
    checkOutput("fixed_neigh", rd_data[1], 32'h5555AAAA);
    readBurst(32'h20, 8'd1, 2'b00, -1, 0);
    checkOutput("fixed_rd1", rd_data[1], 32'h3);

    // Out-of-range read and write
    readBurst(32'h1000, 8'd1, 2'b01, -1, 0);
    checkOutput("oor_resp0", 32'(rd_resp[0]), 32'd2);
    checkOutput("oor_resp1", 32'(rd_resp[1]), 32'd2);
    checkOutput("oor_data0", rd_data[0], 32'h0);
    checkOutput("oor_data1", rd_data[1], 32'h0);
    checkOutput("oor_last1", 32'(rd_last[1]), 32'd1);
    wbeat_data[0] = 32'hDEADBEEF; wbeat_strb[0] = 4'hF;
    writeBurst(32'h1000, 8'd0, 2'b01, -1);
    checkOutput("oor_bresp", 32'(wr_resp), 32'd2);
    readBurst(32'h0, 8'd0, 2'b01, -1, 0);
    checkOutput("oor_mem0", rd_data[0], 32'h11BB33DD);

    // Illegal burst type still returns every beat, flagged
    readBurst(32'h10, 8'd1, 2'b11, -1, 0);
    checkOutput("badburst_resp", 32'(rd_resp[1]), 32'd2);

    // wlast on the wrong beat: error response, data still written
    wbeat_data[0] = 32'h33; wbeat_data[1] = 32'h34; wbeat_strb[0] = 4'hF; wbeat_strb[1] = 4'hF;
    writeBurst(32'h30, 8'd1, 2'b01, 0);
    checkOutput("wlast_bresp", 32'(wr_resp), 32'd2);
    readBurst(32'h30, 8'd1, 2'b01, -1, 0);
    checkOutput("wlast_d0", rd_data[0], 32'h33);
    checkOutput("wlast_d1", rd_data[1], 32'h34);

    // Back-pressure mid-burst loses nothing
    readBurst(32'h10, 8'd3, 2'b01, 1, 5);
    checkOutput("stall_d0", rd_data[0], 32'hA0);
    checkOutput("stall_d1", rd_data[1], 32'hA1);
    checkOutput("stall_d2", rd_data[2], 32'hA2);
    checkOutput("stall_d3", rd_data[3], 32'hA3);
    checkOutput("stall_last3", 32'(rd_last[3]), 32'd1);

    // Reset in the middle of an open write burst and a running read burst
    s_awaddr = 32'h40; s_awlen = 8'd1; s_awsize = 3'd2; s_awburst = 2'b01; s_awvalid = 1'b1;
    n = 0;
    while (!s_awready && n < 20) begin @(negedge axi_aclk); n++; end
    checkOutput("mid_aw_handshake", 32'(n < 20), 32'd1);
    @(negedge axi_aclk);
    s_awvalid = 1'b0;
    s_wdata = 32'h4040; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b1;
    @(negedge axi_aclk);
    s_wvalid = 1'b0;
    s_araddr = 32'h10; s_arlen = 8'd3; s_arburst = 2'b01; s_arsize = 3'd2; s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge axi_aclk); n++; end
    @(negedge axi_aclk);
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin @(negedge axi_aclk); n++; end
    @(negedge axi_aclk);
    checkOutput("mid_rvalid_before", 32'(s_rvalid), 32'd1);
    axi_reset = 1'b1;
    @(negedge axi_aclk);
    checkOutput("mid_rst_rvalid", 32'(s_rvalid), 32'd0);
    checkOutput("mid_rst_bvalid", 32'(s_bvalid), 32'd0);
    axi_reset = 1'b0;
    s_rready = 1'b0;
    s_bready = 1'b1;
    repeat (4) @(negedge axi_aclk);
    checkOutput("mid_after_bvalid", 32'(s_bvalid), 32'd0);
    checkOutput("mid_after_rvalid", 32'(s_rvalid), 32'd0);
    checkOutput("mid_after_arready", 32'(s_arready), 32'd1);
    s_bready = 1'b0;
    readBurst(32'h10, 8'd0, 2'b01, -1, 0);
    checkOutput("mem_kept", rd_data[0], 32'hA0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
